// File: rtl/reservation_station.sv
// reservation_station
// Issue queue in front of the EXE stage. Dispatched instructions wait here
// until both operands are known. The EXE result broadcast (tag + data) wakes
// waiting operands. Each cycle the oldest fully-ready entry is sent to EXE.
//
// Ports
//   CLK, RESET                      clock, asynchronous active-high reset
//   Dispatch_*_IN                   dispatch request: instr, PC, age, control,
//                                   per-operand {ready, tag, data}
//   Bcast_Valid/Tag/Data_IN         EXE result broadcast used for wakeup
//   Flush_IN                        discard every entry and the pending issue
//   IF_stall_request                EXE stalled: hold the issue outputs
//   Full_OUT                        all entries valid; dispatch is dropped
//   Issue_Valid_OUT + *1_OUT        registered issue bundle towards EXE
module reservation_station #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Dispatch_Valid_IN,
    input  logic [31:0]      Dispatch_Instr_IN,
    input  logic [31:0]      Dispatch_PC_IN,
    input  logic [31:0]      Dispatch_Age_IN,
    input  logic [18:0]      Dispatch_Ctrl_IN,
    input  logic             Dispatch_A_Ready_IN,
    input  logic [TAG_W-1:0] Dispatch_A_Tag_IN,
    input  logic [31:0]      Dispatch_A_Data_IN,
    input  logic             Dispatch_B_Ready_IN,
    input  logic [TAG_W-1:0] Dispatch_B_Tag_IN,
    input  logic [31:0]      Dispatch_B_Data_IN,
    input  logic             Bcast_Valid_IN,
    input  logic [TAG_W-1:0] Bcast_Tag_IN,
    input  logic [31:0]      Bcast_Data_IN,
    input  logic             Flush_IN,
    input  logic             IF_stall_request,
    output logic             Full_OUT,
    output logic             Issue_Valid_OUT,
    output logic [31:0]      Instr1_OUT,
    output logic [31:0]      Instr1_PC_OUT,
    output logic [31:0]      OperandA1_OUT,
    output logic [31:0]      OperandB1_OUT,
    output logic [31:0]      InstrAge_OUT,
    output logic [5:0]       ALU_Control1_OUT,
    output logic [4:0]       ShiftAmount1_OUT,
    output logic [4:0]       WriteRegister1_OUT,
    output logic             RegWrite1_OUT,
    output logic             MemRead1_OUT,
    output logic             MemWrite1_OUT
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_a_rdy;
    logic [DEPTH-1:0] r_b_rdy;
    logic [TAG_W-1:0] r_a_tag  [DEPTH];
    logic [TAG_W-1:0] r_b_tag  [DEPTH];
    logic [31:0]      r_a_data [DEPTH];
    logic [31:0]      r_b_data [DEPTH];
    logic [31:0]      r_instr  [DEPTH];
    logic [31:0]      r_pc     [DEPTH];
    logic [31:0]      r_age    [DEPTH];
    logic [18:0]      r_ctrl   [DEPTH];

    // Issue output registers
    logic        r_issue_valid;
    logic [31:0] r_instr_out;
    logic [31:0] r_pc_out;
    logic [31:0] r_opa_out;
    logic [31:0] r_opb_out;
    logic [31:0] r_age_out;
    logic [18:0] r_ctrl_out;

    logic             w_full;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_do_disp;
    logic             w_do_issue;
    logic             w_disp_a_rdy;
    logic             w_disp_b_rdy;
    logic [31:0]      w_disp_a_data;
    logic [31:0]      w_disp_b_data;

    // Wrap-safe age compare: i is older than j when (age_i - age_j) is negative.
    function automatic logic is_older(input logic [31:0] age_i, input logic [31:0] age_j);
        logic [31:0] diff;
        diff = age_i - age_j;
        return diff[31];
    endfunction

    assign w_full     = &r_valid;
    assign Full_OUT   = w_full;
    // Full is judged on registered state only, so a slot freed by this
    // cycle's issue cannot be reused by this cycle's dispatch.
    assign w_do_disp  = Dispatch_Valid_IN & ~w_full & w_free_found;
    assign w_do_issue = w_sel_found & ~IF_stall_request;

    // Same-cycle bypass: an operand produced by this cycle's broadcast is stored ready.
    assign w_disp_a_rdy  = Dispatch_A_Ready_IN | (Bcast_Valid_IN & (Bcast_Tag_IN == Dispatch_A_Tag_IN));
    assign w_disp_b_rdy  = Dispatch_B_Ready_IN | (Bcast_Valid_IN & (Bcast_Tag_IN == Dispatch_B_Tag_IN));
    assign w_disp_a_data = Dispatch_A_Ready_IN ? Dispatch_A_Data_IN : Bcast_Data_IN;
    assign w_disp_b_data = Dispatch_B_Ready_IN ? Dispatch_B_Data_IN : Bcast_Data_IN;

    // Lowest-index free entry for dispatch (scan downwards so the lowest wins).
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end else begin
                w_free_found = w_free_found;
                w_free_idx   = w_free_idx;
            end
        end
    end

    // Oldest entry whose operands are both ready.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_a_rdy[i] && r_b_rdy[i] &&
                (!w_sel_found || is_older(r_age[i], r_age[w_sel_idx]))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end else begin
                w_sel_found = w_sel_found;
                w_sel_idx   = w_sel_idx;
            end
        end
    end

    // Entry state: wakeup, removal on issue, allocation on dispatch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= '0;
            r_a_rdy <= '0;
            r_b_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_a_tag[i]  <= '0;
                r_b_tag[i]  <= '0;
                r_a_data[i] <= 32'd0;
                r_b_data[i] <= 32'd0;
                r_instr[i]  <= 32'd0;
                r_pc[i]     <= 32'd0;
                r_age[i]    <= 32'd0;
                r_ctrl[i]   <= 19'd0;
            end
        end else if (Flush_IN) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (Bcast_Valid_IN && r_valid[i] && !r_a_rdy[i] && (r_a_tag[i] == Bcast_Tag_IN)) begin
                    r_a_rdy[i]  <= 1'b1;
                    r_a_data[i] <= Bcast_Data_IN;
                end
                if (Bcast_Valid_IN && r_valid[i] && !r_b_rdy[i] && (r_b_tag[i] == Bcast_Tag_IN)) begin
                    r_b_rdy[i]  <= 1'b1;
                    r_b_data[i] <= Bcast_Data_IN;
                end
                if (w_do_issue && (w_sel_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                // The dispatch target is a free slot, so it never collides with the issue slot.
                if (w_do_disp && (w_free_idx == IDX_W'(i))) begin
                    r_valid[i]  <= 1'b1;
                    r_a_rdy[i]  <= w_disp_a_rdy;
                    r_b_rdy[i]  <= w_disp_b_rdy;
                    r_a_tag[i]  <= Dispatch_A_Tag_IN;
                    r_b_tag[i]  <= Dispatch_B_Tag_IN;
                    r_a_data[i] <= w_disp_a_data;
                    r_b_data[i] <= w_disp_b_data;
                    r_instr[i]  <= Dispatch_Instr_IN;
                    r_pc[i]     <= Dispatch_PC_IN;
                    r_age[i]    <= Dispatch_Age_IN;
                    r_ctrl[i]   <= Dispatch_Ctrl_IN;
                end
            end
        end
    end

    // Issue bundle: loads the selected entry, held while EXE stalls.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_issue_valid <= 1'b0;
            r_instr_out   <= 32'd0;
            r_pc_out      <= 32'd0;
            r_opa_out     <= 32'd0;
            r_opb_out     <= 32'd0;
            r_age_out     <= 32'd0;
            r_ctrl_out    <= 19'd0;
        end else if (Flush_IN) begin
            r_issue_valid <= 1'b0;
        end else if (!IF_stall_request) begin
            if (w_sel_found) begin
                r_issue_valid <= 1'b1;
                r_instr_out   <= r_instr[w_sel_idx];
                r_pc_out      <= r_pc[w_sel_idx];
                r_opa_out     <= r_a_data[w_sel_idx];
                r_opb_out     <= r_b_data[w_sel_idx];
                r_age_out     <= r_age[w_sel_idx];
                r_ctrl_out    <= r_ctrl[w_sel_idx];
            end else begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign Issue_Valid_OUT    = r_issue_valid;
    assign Instr1_OUT         = r_instr_out;
    assign Instr1_PC_OUT      = r_pc_out;
    assign OperandA1_OUT      = r_opa_out;
    assign OperandB1_OUT      = r_opb_out;
    assign InstrAge_OUT       = r_age_out;
    assign ALU_Control1_OUT   = r_ctrl_out[18:13];
    assign ShiftAmount1_OUT   = r_ctrl_out[12:8];
    assign WriteRegister1_OUT = r_ctrl_out[7:3];
    assign RegWrite1_OUT      = r_ctrl_out[2];
    assign MemRead1_OUT       = r_ctrl_out[1];
    assign MemWrite1_OUT      = r_ctrl_out[0];

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an issue scoreboard.
module tb_reservation_station;

    logic        CLK;
    logic        RESET;
    logic        Dispatch_Valid_IN;
    logic [31:0] Dispatch_Instr_IN;
    logic [31:0] Dispatch_PC_IN;
    logic [31:0] Dispatch_Age_IN;
    logic [18:0] Dispatch_Ctrl_IN;
    logic        Dispatch_A_Ready_IN;
    logic [5:0]  Dispatch_A_Tag_IN;
    logic [31:0] Dispatch_A_Data_IN;
    logic        Dispatch_B_Ready_IN;
    logic [5:0]  Dispatch_B_Tag_IN;
    logic [31:0] Dispatch_B_Data_IN;
    logic        Bcast_Valid_IN;
    logic [5:0]  Bcast_Tag_IN;
    logic [31:0] Bcast_Data_IN;
    logic        Flush_IN;
    logic        IF_stall_request;
    logic        Full_OUT;
    logic        Issue_Valid_OUT;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr1_PC_OUT;
    logic [31:0] OperandA1_OUT;
    logic [31:0] OperandB1_OUT;
    logic [31:0] InstrAge_OUT;
    logic [5:0]  ALU_Control1_OUT;
    logic [4:0]  ShiftAmount1_OUT;
    logic [4:0]  WriteRegister1_OUT;
    logic        RegWrite1_OUT;
    logic        MemRead1_OUT;
    logic        MemWrite1_OUT;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] age;
        logic [18:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reservation_station #(.DEPTH(8), .TAG_W(6)) dut (
        .CLK(CLK), .RESET(RESET),
        .Dispatch_Valid_IN(Dispatch_Valid_IN), .Dispatch_Instr_IN(Dispatch_Instr_IN),
        .Dispatch_PC_IN(Dispatch_PC_IN), .Dispatch_Age_IN(Dispatch_Age_IN),
        .Dispatch_Ctrl_IN(Dispatch_Ctrl_IN),
        .Dispatch_A_Ready_IN(Dispatch_A_Ready_IN), .Dispatch_A_Tag_IN(Dispatch_A_Tag_IN),
        .Dispatch_A_Data_IN(Dispatch_A_Data_IN),
        .Dispatch_B_Ready_IN(Dispatch_B_Ready_IN), .Dispatch_B_Tag_IN(Dispatch_B_Tag_IN),
        .Dispatch_B_Data_IN(Dispatch_B_Data_IN),
        .Bcast_Valid_IN(Bcast_Valid_IN), .Bcast_Tag_IN(Bcast_Tag_IN), .Bcast_Data_IN(Bcast_Data_IN),
        .Flush_IN(Flush_IN), .IF_stall_request(IF_stall_request),
        .Full_OUT(Full_OUT), .Issue_Valid_OUT(Issue_Valid_OUT),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
        .OperandA1_OUT(OperandA1_OUT), .OperandB1_OUT(OperandB1_OUT),
        .InstrAge_OUT(InstrAge_OUT), .ALU_Control1_OUT(ALU_Control1_OUT),
        .ShiftAmount1_OUT(ShiftAmount1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
        .RegWrite1_OUT(RegWrite1_OUT), .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] age, input logic [18:0] ctrl);
        exp_t e;
        e.instr = instr; e.pc = pc; e.a = a; e.b = b; e.age = age; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    // One clock; a fresh issue (edge not stalled/flushed/reset) is checked against the scoreboard.
    task automatic step();
        logic  st;
        exp_t  e;
        logic [18:0] ctrl_obs;
        st = IF_stall_request | Flush_IN | RESET;
        @(posedge CLK);
        #1;
        if (!st && Issue_Valid_OUT) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_issue: observed issue of age %h expected no issue", InstrAge_OUT);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                ctrl_obs = {ALU_Control1_OUT, ShiftAmount1_OUT, WriteRegister1_OUT,
                            RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT};
                chk("issue_age",   InstrAge_OUT,   e.age);
                chk("issue_instr", Instr1_OUT,     e.instr);
                chk("issue_pc",    Instr1_PC_OUT,  e.pc);
                chk("issue_opa",   OperandA1_OUT,  e.a);
                chk("issue_opb",   OperandB1_OUT,  e.b);
                chk("issue_ctrl",  {13'd0, ctrl_obs}, {13'd0, e.ctrl});
            end
        end
    endtask

    task automatic dispatch(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] age,
                            input logic [18:0] ctrl,
                            input logic a_rdy, input logic [5:0] a_tag, input logic [31:0] a_data,
                            input logic b_rdy, input logic [5:0] b_tag, input logic [31:0] b_data);
        Dispatch_Valid_IN   = 1'b1;
        Dispatch_Instr_IN   = instr;
        Dispatch_PC_IN      = pc;
        Dispatch_Age_IN     = age;
        Dispatch_Ctrl_IN    = ctrl;
        Dispatch_A_Ready_IN = a_rdy;
        Dispatch_A_Tag_IN   = a_tag;
        Dispatch_A_Data_IN  = a_data;
        Dispatch_B_Ready_IN = b_rdy;
        Dispatch_B_Tag_IN   = b_tag;
        Dispatch_B_Data_IN  = b_data;
        step();
        Dispatch_Valid_IN   = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        Dispatch_Valid_IN = 1'b0; Dispatch_Instr_IN = 32'd0; Dispatch_PC_IN = 32'd0;
        Dispatch_Age_IN = 32'd0; Dispatch_Ctrl_IN = 19'd0;
        Dispatch_A_Ready_IN = 1'b0; Dispatch_A_Tag_IN = 6'd0; Dispatch_A_Data_IN = 32'd0;
        Dispatch_B_Ready_IN = 1'b0; Dispatch_B_Tag_IN = 6'd0; Dispatch_B_Data_IN = 32'd0;
        Bcast_Valid_IN = 1'b0; Bcast_Tag_IN = 6'd0; Bcast_Data_IN = 32'd0;
        Flush_IN = 1'b0; IF_stall_request = 1'b0;

        // Reset state
        #2 RESET = 1'b1;
        step();
        step();
        chk("rst_issue_valid", {31'd0, Issue_Valid_OUT}, 32'd0);
        chk("rst_full",        {31'd0, Full_OUT},        32'd0);
        chk("rst_opa",         OperandA1_OUT,            32'd0);
        chk("rst_age",         InstrAge_OUT,             32'd0);
        RESET = 1'b0;
        step();
        chk("idle_no_issue", {31'd0, Issue_Valid_OUT}, 32'd0);

        // Both operands ready at dispatch: issue on the following edge
        push_exp(32'h00A5_0033, 32'h0000_0100, 32'd5, 32'd7, 32'd1, {6'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0});
        dispatch(32'h00A5_0033, 32'h0000_0100, 32'd1, {6'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0},
                 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
        chk("t2_not_same_edge", {31'd0, Issue_Valid_OUT}, 32'd0);
        step();
        chk("t2_issue_valid", {31'd0, Issue_Valid_OUT}, 32'd1);
        step();
        chk("t2_drained", {31'd0, Issue_Valid_OUT}, 32'd0);

        // Wakeup through the broadcast three cycles after dispatch
        push_exp(32'h0000_1111, 32'h0000_0104, 32'h0000_DEAD, 32'd3, 32'd2, {6'd5, 5'd4, 5'd9, 1'b1, 1'b0, 1'b1});
        dispatch(32'h0000_1111, 32'h0000_0104, 32'd2, {6'd5, 5'd4, 5'd9, 1'b1, 1'b0, 1'b1},
                 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_waiting", {31'd0, Issue_Valid_OUT}, 32'd0);
        end
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd12; Bcast_Data_IN = 32'h0000_DEAD;
        step();
        Bcast_Valid_IN = 1'b0;
        chk("t3_wake_edge_no_issue", {31'd0, Issue_Valid_OUT}, 32'd0);
        step();
        chk("t3_issue_valid", {31'd0, Issue_Valid_OUT}, 32'd1);
        step();

        // Same-cycle bypass from the broadcast into dispatch
        push_exp(32'h0000_2222, 32'h0000_0108, 32'h0000_1234, 32'h0000_0055, 32'd3, {6'd7, 5'd31, 5'd1, 1'b0, 1'b1, 1'b0});
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd9; Bcast_Data_IN = 32'h0000_1234;
        dispatch(32'h0000_2222, 32'h0000_0108, 32'd3, {6'd7, 5'd31, 5'd1, 1'b0, 1'b1, 1'b0},
                 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'h0000_0055);
        Bcast_Valid_IN = 1'b0;
        step();
        chk("t4_issue_valid", {31'd0, Issue_Valid_OUT}, 32'd1);
        step();

        // Age wrap: the younger-index entry (age 1) sits in slot 0, 0xFFFFFFFF is older
        dispatch(32'h0000_3331, 32'h0000_0200, 32'h0000_0001, 19'h1_2345,
                 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'h0000_0A01);
        dispatch(32'h0000_3332, 32'h0000_0204, 32'hFFFF_FFFF, 19'h0_5432,
                 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'h0000_0A02);
        push_exp(32'h0000_3332, 32'h0000_0204, 32'h0000_0777, 32'h0000_0A02, 32'hFFFF_FFFF, 19'h0_5432);
        push_exp(32'h0000_3331, 32'h0000_0200, 32'h0000_0777, 32'h0000_0A01, 32'h0000_0001, 19'h1_2345);
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd30; Bcast_Data_IN = 32'h0000_0777;
        step();
        Bcast_Valid_IN = 1'b0;
        step();
        chk("t5_first_age", InstrAge_OUT, 32'hFFFF_FFFF);
        step();
        chk("t5_second_age", InstrAge_OUT, 32'h0000_0001);
        step();
        chk("t5_drained", {31'd0, Issue_Valid_OUT}, 32'd0);

        // Fill all entries with waiting operands
        for (int i = 0; i < 8; i++) begin
            dispatch(32'h0000_1000 + 32'(i), 32'h0000_2000 + 32'(4 * i), 32'd10 + 32'(i), 19'(i * 777 + 5),
                     1'b0, 6'(40 + i), 32'd0, 1'b1, 6'd0, 32'h0000_0300 + 32'(i));
            if (i == 6) chk("t6_not_full_at_7", {31'd0, Full_OUT}, 32'd0);
        end
        chk("t6_full", {31'd0, Full_OUT}, 32'd1);
        dispatch(32'h0000_9999, 32'h0000_9990, 32'd18, 19'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
        chk("t6_still_full", {31'd0, Full_OUT}, 32'd1);
        step();
        chk("t6_dropped_no_issue", {31'd0, Issue_Valid_OUT}, 32'd0);

        // Wake slot 0 and let it issue
        push_exp(32'h0000_1000, 32'h0000_2000, 32'h0000_A0A0, 32'h0000_0300, 32'd10, 19'd5);
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd40; Bcast_Data_IN = 32'h0000_A0A0;
        step();
        Bcast_Valid_IN = 1'b0;
        step();
        chk("t6_issue_slot0", {31'd0, Issue_Valid_OUT}, 32'd1);

        // Stall two cycles while slot 1 wakes: outputs hold
        IF_stall_request = 1'b1;
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd41; Bcast_Data_IN = 32'h0000_B1B1;
        for (int k = 0; k < 2; k++) begin
            step();
            Bcast_Valid_IN = 1'b0;
            chk("stall_valid_held", {31'd0, Issue_Valid_OUT}, 32'd1);
            chk("stall_opa_held",   OperandA1_OUT,            32'h0000_A0A0);
            chk("stall_age_held",   InstrAge_OUT,             32'd10);
        end
        IF_stall_request = 1'b0;
        push_exp(32'h0000_1001, 32'h0000_2004, 32'h0000_B1B1, 32'h0000_0301, 32'd11, 19'd782);
        step();
        chk("post_stall_issue", {31'd0, Issue_Valid_OUT}, 32'd1);

        // Refill to full, make slot 2 ready, then flush before it can issue
        dispatch(32'h0000_4000, 32'h0000_4000, 32'd20, 19'd9, 1'b0, 6'd50, 32'd0, 1'b0, 6'd50, 32'd0);
        dispatch(32'h0000_4001, 32'h0000_4004, 32'd21, 19'd9, 1'b0, 6'd50, 32'd0, 1'b0, 6'd50, 32'd0);
        chk("refill_full", {31'd0, Full_OUT}, 32'd1);
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd42; Bcast_Data_IN = 32'h0000_C2C2;
        step();
        Bcast_Valid_IN = 1'b0;
        Flush_IN = 1'b1;
        step();
        Flush_IN = 1'b0;
        chk("flush_issue_valid", {31'd0, Issue_Valid_OUT}, 32'd0);
        chk("flush_full",        {31'd0, Full_OUT},        32'd0);
        for (int t = 43; t <= 50; t++) begin
            Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'(t); Bcast_Data_IN = 32'(t);
            step();
        end
        Bcast_Valid_IN = 1'b0;
        step();
        chk("flush_nothing_left", {31'd0, Issue_Valid_OUT}, 32'd0);

        // Reset pulse with three entries held
        for (int i = 0; i < 3; i++) begin
            dispatch(32'h0000_5000 + 32'(i), 32'h0000_5100, 32'd30 + 32'(i), 19'd3,
                     1'b0, 6'd60, 32'd0, 1'b1, 6'd0, 32'd1);
        end
        RESET = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, Issue_Valid_OUT}, 32'd0);
        chk("mid_rst_full",  {31'd0, Full_OUT},        32'd0);
        chk("mid_rst_instr", Instr1_OUT,               32'd0);
        chk("mid_rst_opb",   OperandB1_OUT,            32'd0);
        step();
        RESET = 1'b0;
        Bcast_Valid_IN = 1'b1; Bcast_Tag_IN = 6'd60; Bcast_Data_IN = 32'h0000_6060;
        step();
        Bcast_Valid_IN = 1'b0;
        step();
        chk("post_rst_no_issue", {31'd0, Issue_Valid_OUT}, 32'd0);
        push_exp(32'h0000_7000, 32'h0000_7004, 32'h0000_0011, 32'h0000_0022, 32'd40, 19'h7_0F0F);
        dispatch(32'h0000_7000, 32'h0000_7004, 32'd40, 19'h7_0F0F, 1'b1, 6'd0, 32'h0000_0011, 1'b1, 6'd0, 32'h0000_0022);
        step();
        chk("post_rst_issue", {31'd0, Issue_Valid_OUT}, 32'd1);
        step();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
